// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width defaults and load-type encodings
// used by the MEM and WB stages.
package pipeline_pkg;

  localparam int DATA_W_DEFAULT     = 32;
  localparam int REG_ADDR_W_DEFAULT = 5;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LB  = 3'b001,
    LT_LBU = 3'b010,
    LT_LH  = 3'b011,
    LT_LHU = 3'b100
  } load_type_e;

endpackage

// File: rtl/load_extract.sv
// Little-endian byte/halfword selection with sign or zero extension for loads.
// Purely combinational so the MEM-stage forwarding path can share it.
module load_extract
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] readData,
  input  logic [1:0]        addrLow,
  input  logic [2:0]        loadType,
  output logic [DATA_W-1:0] extData
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = readData[{addrLow, 3'b000} +: 8];
    // Halfword loads are assumed aligned, so addrLow[0] plays no part.
    half_sel = readData[{addrLow[1], 4'b0000} +: 16];
    case (loadType)
      LT_LB:   extData = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LT_LBU:  extData = {{(DATA_W-8){1'b0}}, byte_sel};
      LT_LH:   extData = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LT_LHU:  extData = {{(DATA_W-16){1'b0}}, half_sel};
      default: extData = readData;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, write-back mux and a
// retired-instruction counter feeding the register file and forwarding unit.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  mem_valid,
  input  logic                  mem_regWrite,
  input  logic                  mem_memToReg,
  input  logic [2:0]            mem_loadType,
  input  logic [1:0]            mem_addrLow,
  input  logic [DATA_W-1:0]     mem_aluResult,
  input  logic [DATA_W-1:0]     mem_readData,
  input  logic [REG_ADDR_W-1:0] mem_writeReg,
  output logic [DATA_W-1:0]     outMuxWb,
  output logic                  wb_regWrite,
  output logic [REG_ADDR_W-1:0] wb_writeReg,
  output logic                  wb_valid,
  output logic [31:0]           instret
);

  logic                  valid_q, valid_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic [2:0]            load_type_q, load_type_d;
  logic [1:0]            addr_low_q, addr_low_d;
  logic [DATA_W-1:0]     alu_result_q, alu_result_d;
  logic [DATA_W-1:0]     read_data_q, read_data_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [31:0]           instret_q, instret_d;
  logic [DATA_W-1:0]     load_data;

  always_comb begin
    // NOTE: every next-state signal defaults to its held value first, so no path leaves one unassigned and no latch is inferred.
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    load_type_d  = load_type_q;
    addr_low_d   = addr_low_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    write_reg_d  = write_reg_q;
    instret_d    = instret_q;

    if (flush_i) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (!stall_i) begin
      valid_d      = mem_valid;
      reg_write_d  = mem_regWrite;
      mem_to_reg_d = mem_memToReg;
      load_type_d  = mem_loadType;
      addr_low_d   = mem_addrLow;
      alu_result_d = mem_aluResult;
      read_data_d  = mem_readData;
      write_reg_d  = mem_writeReg;
    end

    // Counts the instruction leaving WB, so a flush on the same edge does not cancel it.
    if (valid_q && !stall_i) begin
      instret_d = instret_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      load_type_q  <= '0;
      addr_low_q   <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      write_reg_q  <= '0;
      instret_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      load_type_q  <= load_type_d;
      addr_low_q   <= addr_low_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      write_reg_q  <= write_reg_d;
      instret_q    <= instret_d;
    end
  end

  load_extract #(.DATA_W(DATA_W)) u_load_extract (
    .readData (read_data_q),
    .addrLow  (addr_low_q),
    .loadType (load_type_q),
    .extData  (load_data)
  );

  assign outMuxWb    = mem_to_reg_q ? load_data : alu_result_q;
  assign wb_regWrite = reg_write_q && valid_q && (write_reg_q != '0);
  assign wb_writeReg = write_reg_q;
  assign wb_valid    = valid_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a behavioural model
// of the write-back stage built from plain arithmetic.
module tb_mem_wb_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, stall_i, flush_i;
  logic        in_valid, in_rw, in_m2r;
  logic [2:0]  in_lt;
  logic [1:0]  in_al;
  logic [31:0] in_alu, in_rd;
  logic [4:0]  in_wr;
  logic [31:0] outMuxWb, instret;
  logic        wb_regWrite, wb_valid;
  logic [4:0]  wb_writeReg;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of what the WB stage currently holds.
  bit          m_valid, m_rw, m_m2r;
  logic [2:0]  m_lt;
  logic [1:0]  m_al;
  logic [31:0] m_alu, m_rd, m_cnt;
  logic [4:0]  m_wr;

  mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .mem_valid     (in_valid),
    .mem_regWrite  (in_rw),
    .mem_memToReg  (in_m2r),
    .mem_loadType  (in_lt),
    .mem_addrLow   (in_al),
    .mem_aluResult (in_alu),
    .mem_readData  (in_rd),
    .mem_writeReg  (in_wr),
    .outMuxWb      (outMuxWb),
    .wb_regWrite   (wb_regWrite),
    .wb_writeReg   (wb_writeReg),
    .wb_valid      (wb_valid),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_load(logic [31:0] rd, logic [2:0] lt, logic [1:0] al);
    logic [31:0] b, h;
    b = (rd >> (8 * al)) & 32'h0000_00FF;
    h = (rd >> (16 * (al / 2))) & 32'h0000_FFFF;
    case (lt)
      3'd1:    return (b >= 32'd128)    ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'h8000)   ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] exp_out();
    return m_m2r ? ref_load(m_rd, m_lt, m_al) : m_alu;
  endfunction

  function automatic logic exp_rw();
    return m_rw && m_valid && (m_wr != 5'd0);
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_lt = '0; m_al = '0;
      m_alu = '0; m_rd = '0; m_wr = '0; m_cnt = '0;
    end else begin
      if (m_valid && !stall_i) m_cnt = m_cnt + 1;
      if (flush_i) begin
        m_valid = 0; m_rw = 0;
      end else if (!stall_i) begin
        m_valid = in_valid; m_rw = in_rw; m_m2r = in_m2r; m_lt = in_lt;
        m_al = in_al; m_alu = in_alu; m_rd = in_rd; m_wr = in_wr;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_inputs();
    in_valid = 1'($urandom_range(0, 1));
    in_rw    = 1'($urandom_range(0, 1));
    in_m2r   = 1'($urandom_range(0, 1));
    in_lt    = 3'($urandom_range(0, 7));
    in_al    = 2'($urandom_range(0, 3));
    in_alu   = $urandom;
    in_rd    = $urandom;
    in_wr    = 5'($urandom_range(0, 31));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin
      rand_inputs();
      stall_i = 1'($urandom_range(0, 1));
      flush_i = 1'($urandom_range(0, 1));
      tick();
      vectors += 5;
      if (outMuxWb !== 32'd0) begin miscompares++; $display("FAIL reset_out: got %h want 0", outMuxWb); end
      if (wb_regWrite !== 1'b0) begin miscompares++; $display("FAIL reset_rw: got %b want 0", wb_regWrite); end
      if (wb_writeReg !== 5'd0) begin miscompares++; $display("FAIL reset_wr: got %0d want 0", wb_writeReg); end
      if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", wb_valid); end
      if (instret !== 32'd0) begin miscompares++; $display("FAIL reset_instret: got %h want 0", instret); end
    end
    rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0; in_valid = 1'b0;
    tick();
    vectors++;
    if (instret !== 32'd0) begin miscompares++; $display("FAIL release_instret: got %h want 0", instret); end
  endtask

  task automatic test_alu();
    in_alu = 32'h1234_5678; in_m2r = 1'b0; in_wr = 5'd8; in_rw = 1'b1; in_valid = 1'b1;
    in_rd = $urandom; in_lt = 3'($urandom_range(0, 7));
    tick();
    vectors += 5;
    if (outMuxWb !== 32'h1234_5678) begin miscompares++; $display("FAIL alu_out: got %h want 12345678", outMuxWb); end
    if (wb_regWrite !== 1'b1) begin miscompares++; $display("FAIL alu_rw: got %b want 1", wb_regWrite); end
    if (wb_writeReg !== 5'd8) begin miscompares++; $display("FAIL alu_wr: got %0d want 8", wb_writeReg); end
    if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL alu_valid: got %b want 1", wb_valid); end
    if (instret !== 32'd0) begin miscompares++; $display("FAIL alu_instret_pre: got %h want 0", instret); end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (instret !== 32'd1) begin miscompares++; $display("FAIL alu_instret: got %h want 1", instret); end
  endtask

  task automatic test_load_sweep();
    logic [2:0]  lt_tab  [8] = '{LT_LB, LT_LB, LT_LB, LT_LB, LT_LBU, LT_LH, LT_LHU, LT_LH};
    logic [1:0]  al_tab  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0, 2'd1};
    logic [31:0] exp_tab [8] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80,
                                 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h0000_7F01};
    for (int i = 0; i < 8; i++) begin
      in_rd = 32'h80FF_7F01; in_m2r = 1'b1; in_valid = 1'b1; in_rw = 1'b1;
      in_lt = lt_tab[i]; in_al = al_tab[i];
      in_wr = 5'($urandom_range(1, 31)); in_alu = $urandom;
      tick();
      vectors += 2;
      if (outMuxWb !== exp_tab[i]) begin
        miscompares++; $display("FAIL load_sweep[%0d]: got %h want %h", i, outMuxWb, exp_tab[i]);
      end
      if (wb_regWrite !== 1'b1) begin
        miscompares++; $display("FAIL load_sweep_rw[%0d]: got %b want 1", i, wb_regWrite);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] alu_v, base;
    alu_v = $urandom;
    in_valid = 1'b1; in_rw = 1'b1; in_wr = 5'd0; in_m2r = 1'b0; in_alu = alu_v;
    tick();
    vectors += 3;
    if (wb_regWrite !== 1'b0) begin miscompares++; $display("FAIL zero_rw: got %b want 0", wb_regWrite); end
    if (outMuxWb !== alu_v) begin miscompares++; $display("FAIL zero_out: got %h want %h", outMuxWb, alu_v); end
    if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL zero_valid: got %b want 1", wb_valid); end
    base = m_cnt;
    in_valid = 1'b0;
    tick();
    vectors++;
    if (instret !== base + 32'd1) begin miscompares++; $display("FAIL zero_instret: got %h want %h", instret, base + 32'd1); end
  endtask

  task automatic test_stall_flush();
    logic [31:0] held_out, held_cnt;
    logic [4:0]  held_wr;
    in_valid = 1'b1; in_rw = 1'b1; in_wr = 5'($urandom_range(1, 31)); in_m2r = 1'b1;
    in_lt = LT_LBU; in_al = 2'($urandom_range(0, 3)); in_rd = $urandom;
    tick();
    held_out = ref_load(in_rd, in_lt, in_al);
    held_wr  = in_wr;
    held_cnt = m_cnt;
    stall_i = 1'b1;
    repeat (3) begin
      rand_inputs();
      tick();
      vectors += 4;
      if (outMuxWb !== held_out) begin miscompares++; $display("FAIL stall_out: got %h want %h", outMuxWb, held_out); end
      if (wb_writeReg !== held_wr) begin miscompares++; $display("FAIL stall_wr: got %0d want %0d", wb_writeReg, held_wr); end
      if (wb_regWrite !== 1'b1) begin miscompares++; $display("FAIL stall_rw: got %b want 1", wb_regWrite); end
      if (instret !== held_cnt) begin miscompares++; $display("FAIL stall_instret: got %h want %h", instret, held_cnt); end
    end
    flush_i = 1'b1;
    tick();
    vectors += 3;
    if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_stall_valid: got %b want 0", wb_valid); end
    if (wb_regWrite !== 1'b0) begin miscompares++; $display("FAIL flush_stall_rw: got %b want 0", wb_regWrite); end
    if (instret !== held_cnt) begin miscompares++; $display("FAIL flush_stall_instret: got %h want %h", instret, held_cnt); end
    // Flush while a valid instruction retires: the retire is still counted.
    flush_i = 1'b0; stall_i = 1'b0; in_valid = 1'b1; in_rw = 1'b1;
    tick();
    held_cnt = m_cnt;
    flush_i = 1'b1;
    tick();
    vectors += 2;
    if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b want 0", wb_valid); end
    if (instret !== held_cnt + 32'd1) begin miscompares++; $display("FAIL flush_instret: got %h want %h", instret, held_cnt + 32'd1); end
    // Reset during stall and flush takes priority.
    in_valid = 1'b1;
    tick();
    flush_i = 1'b0; stall_i = 1'b1;
    tick();
    rst_n = 1'b0; flush_i = 1'b1;
    tick();
    vectors += 3;
    if (instret !== 32'd0) begin miscompares++; $display("FAIL rst_stall_instret: got %h want 0", instret); end
    if (outMuxWb !== 32'd0) begin miscompares++; $display("FAIL rst_stall_out: got %h want 0", outMuxWb); end
    if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL rst_stall_valid: got %b want 0", wb_valid); end
    rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_wrap();
    in_valid = 1'b1; in_rw = 1'b1; in_wr = 5'd3;
    tick();
    @(negedge clk);
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_cnt = 32'hFFFF_FFFF;
    in_valid = 1'b0;
    tick();
    vectors++;
    if (instret !== 32'd0) begin miscompares++; $display("FAIL wrap_instret: got %h want 0", instret); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst_n   = ($urandom_range(0, 49) != 0);
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      rand_inputs();
      tick();
      vectors += 5;
      if (outMuxWb !== exp_out()) begin miscompares++; $display("FAIL rnd_out[%0d]: got %h want %h", i, outMuxWb, exp_out()); end
      if (wb_regWrite !== exp_rw()) begin miscompares++; $display("FAIL rnd_rw[%0d]: got %b want %b", i, wb_regWrite, exp_rw()); end
      if (wb_writeReg !== m_wr) begin miscompares++; $display("FAIL rnd_wr[%0d]: got %0d want %0d", i, wb_writeReg, m_wr); end
      if (wb_valid !== m_valid) begin miscompares++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, wb_valid, m_valid); end
      if (instret !== m_cnt) begin miscompares++; $display("FAIL rnd_instret[%0d]: got %h want %h", i, instret, m_cnt); end
    end
    rst_n = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    rand_inputs();
    @(negedge clk);
    test_reset();
    test_alu();
    test_load_sweep();
    test_zero_reg();
    test_stall_flush();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and write-back stage of the 5-stage MIPS pipeline. It captures the memory-stage results and performs load byte/halfword extraction with sign or zero extension. It produces the write-back mux output `outMuxWb` together with the register-file write controls, and counts retired instructions. It sits between the data-memory stage and the register file / forwarding unit.

## Interface
Parameters:
- `DATA_W`, 32, datapath width
- `REG_ADDR_W`, 5, register index width

Ports:
- `clk`  in  1  pipeline clock; all state updates on its rising edge
- `rst_n`  in  1  synchronous active-low reset
- `stall_i`  in  1  hold the MEM/WB register contents
- `flush_i`  in  1  load a bubble into the MEM/WB register
- `mem_valid`  in  1  MEM stage holds a real instruction
- `mem_regWrite`  in  1  instruction writes a register
- `mem_memToReg`  in  1  1 = write-back memory data, 0 = ALU result
- `mem_loadType`  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; other codes are treated as LW
- `mem_addrLow`  in  2  low two bits of the load address
- `mem_aluResult`  in  DATA_W  ALU result
- `mem_readData`  in  DATA_W  raw data-memory word
- `mem_writeReg`  in  REG_ADDR_W  destination register
- `outMuxWb`  out  DATA_W  write-back value
- `wb_regWrite`  out  1  register-file write enable
- `wb_writeReg`  out  REG_ADDR_W  register-file write address
- `wb_valid`  out  1  WB stage holds a real instruction
- `instret`  out  32  retired-instruction counter

## Operation
- Register priority on each edge: `!rst_n` > `flush_i` > `stall_i` > normal capture.
- Reset clears all captured fields, `wb_valid`, and `instret` to 0.
- Flush clears `valid` and `regWrite` only. Data fields may keep their old values.
- Stall holds every captured field.
- Normal capture: all `mem_*` inputs are registered.
- Load extraction works on the registered `readData`, little-endian (byte 0 = bits 7:0):
  - LB/LBU select the byte at `addrLow`.
  - LH/LHU select the halfword at `addrLow[1]`; `addrLow[0]` is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- `outMuxWb` = `memToReg` ? extracted load : `aluResult`. It is combinational from the registered fields.
- `wb_regWrite` = reg `regWrite` & reg `valid` & (reg `writeReg` != 0). Writes to $zero are suppressed.
- `wb_writeReg` = reg `writeReg`.
- `instret` increments on each edge where `wb_valid` & `!stall_i` & `rst_n`. It wraps from 0xFFFFFFFF to 0.
- Flush and increment in the same edge: the increment still applies, because it counts the instruction leaving WB.

## Timing
- Latency: inputs sampled at edge N appear on all outputs after edge N, within the same cycle, through combinational extraction and mux only.
- The register file consumes `wb_regWrite`/`wb_writeReg`/`outMuxWb` at edge N+1.
- Reset values: `outMuxWb` = 0, `wb_regWrite` = 0, `wb_writeReg` = 0, `wb_valid` = 0, `instret` = 0.
- Reset asserted mid-stall or mid-flush: reset wins on that edge.
- Stall held for k cycles: outputs stay constant for k cycles; `instret` does not advance.
- Stall with `wb_valid` = 1 repeats the same register-file write each cycle. This is idempotent and allowed.
- No combinational path from any `mem_*` input to any output.

## Structure
- Shared package `pipeline_pkg` holds:
  - load-type constants `LT_LW`, `LT_LB`, `LT_LBU`, `LT_LH`, `LT_LHU`
  - `DATA_W`/`REG_ADDR_W` defaults
- Sub-module `load_extract`: purely combinational. Inputs are `readData`, `addrLow`, `loadType`; output is the extended word. It is reused later by the MEM-stage forwarding path.
- The top level holds the MEM/WB register, the write-back mux, and the counter.

## Test plan
1. Reset asserted for 2 cycles with random inputs -> all outputs 0. `instret` = 0 after release.
2. ALU op: `aluResult` = 0x12345678, `memToReg` = 0, `writeReg` = 8, `regWrite` = 1, `valid` = 1 -> after one edge `outMuxWb` = 0x12345678, `wb_regWrite` = 1, `wb_writeReg` = 8. `instret` = 1 after the next edge.
3. `readData` = 0x80FF7F01 with sweeps:
   - LB at `addrLow` 0..3 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80
   - LBU at `addrLow` 3 -> 0x00000080
   - LH at `addrLow` 2 -> 0xFFFF80FF
   - LHU at `addrLow` 0 -> 0x00007F01
   - LH at `addrLow` 1 -> 0x00007F01
4. `writeReg` = 0 with `regWrite` = 1 -> `wb_regWrite` = 0, `outMuxWb` still driven, `instret` still increments.
5. Stall for 3 cycles while inputs change -> outputs frozen, `instret` frozen. Then flush with stall also high -> `wb_valid` = 0, `wb_regWrite` = 0 (flush wins).
6. Preload `instret` to 0xFFFFFFFF through a bench force, then one valid retire -> `instret` = 0.
